// File: rtl/axis_traffic_pkg.sv
// rtl/axis_traffic_pkg.sv - shared constants, generator states and beat encoding for the traffic tile
package axis_traffic_pkg;

    localparam int SeqLsb  = 16;
    localparam int BeatLsb = 8;
    localparam int LenLsb  = 0;

    localparam logic [31:0] PatternMask = 32'hA5A5A5A5;
    localparam logic [15:0] LfsrSeed    = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LfsrTaps    = 16'hB400;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_SEND,
        GEN_GAP
    } gen_state_e;

    function automatic logic [31:0] make_beat(input logic [15:0] seq,
                                              input logic [7:0]  beat,
                                              input logic [7:0]  len_m1);
        return {seq, beat, len_m1};
    endfunction

endpackage

// File: rtl/axis_traffic_checker.sv
// rtl/axis_traffic_checker.sv - s_axis sink: per-tid sequence contexts, error and packet counters
module axis_traffic_checker
    import axis_traffic_pkg::*;
#(
    parameter int TDataWidth = 64,
    parameter int TIdWidth   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  random_ready_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [TDataWidth-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tlast_i,
    input  logic [TIdWidth-1:0]   s_axis_tid_i,
    output logic [15:0]           rx_packet_count_o,
    output logic [15:0]           error_count_o,
    output logic                  error_o
);

    localparam int NumCtx = 1 << TIdWidth;

    logic [15:0] exp_seq_q  [NumCtx];
    logic [7:0]  exp_beat_q [NumCtx];
    logic [15:0] lfsr_q;
    logic [15:0] rx_count_q, err_count_q;
    logic        error_q;

    logic        hs, upper_bad, beat_err;
    logic [31:0] low;
    logic [15:0] rx_seq;
    logic [7:0]  rx_beat, rx_len_m1;

    assign s_axis_tready_o = random_ready_i ? lfsr_q[0] : 1'b1;
    assign hs        = s_axis_tvalid_i && s_axis_tready_o;
    assign low       = s_axis_tdata_i[31:0];
    assign rx_seq    = low[SeqLsb +: 16];
    assign rx_beat   = low[BeatLsb +: 8];
    assign rx_len_m1 = low[LenLsb +: 8];

    always_comb begin
        upper_bad = 1'b0;
        for (int i = 32; i < TDataWidth; i++) begin
            if (s_axis_tdata_i[i] != (low[i % 32] ^ PatternMask[i % 32])) upper_bad = 1'b1;
        end
    end

    // Sequence is only meaningful on the first beat; later beats are judged by index and framing.
    assign beat_err = ((rx_beat == 8'd0) && (rx_seq != exp_seq_q[s_axis_tid_i]))
                   || (rx_beat != exp_beat_q[s_axis_tid_i])
                   || (s_axis_tlast_i != (rx_beat == rx_len_m1))
                   || upper_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q      <= LfsrSeed;
            rx_count_q  <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
            for (int c = 0; c < NumCtx; c++) begin
                exp_seq_q[c]  <= '0;
                exp_beat_q[c] <= '0;
            end
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
            // Contexts always follow the received stream so one bad beat reports once, not forever.
            if (hs) begin
                exp_beat_q[s_axis_tid_i] <= s_axis_tlast_i ? 8'd0 : rx_beat + 8'd1;
                if (s_axis_tlast_i) exp_seq_q[s_axis_tid_i] <= rx_seq + 16'd1;
            end
            if (clear_i) begin
                rx_count_q  <= '0;
                err_count_q <= '0;
                error_q     <= 1'b0;
            end else if (hs) begin
                if (s_axis_tlast_i) rx_count_q <= rx_count_q + 16'd1;
                if (beat_err) begin
                    if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                    error_q <= 1'b1;
                end
            end
        end
    end

    assign rx_packet_count_o = rx_count_q;
    assign error_count_o     = err_count_q;
    assign error_o           = error_q;

endmodule

// File: rtl/axis_traffic_tile.sv
// rtl/axis_traffic_tile.sv - AXI-Stream traffic generator and checker tile for NoC PE slots
module axis_traffic_tile
    import axis_traffic_pkg::*;
#(
    parameter int TDataWidth      = 64,
    parameter int TIdWidth        = 5,
    parameter int TDestWidth      = 5,
    parameter int NumStreams      = 4,
    parameter int MaxPacketLength = 16,
    parameter int SrcId           = 0
) (
    input  logic                             clk_axis_i,
    input  logic                             rst_axis_i,
    input  logic                             start_i,
    input  logic [15:0]                      num_packets_i,
    input  logic [7:0]                       packet_length_i,
    input  logic [3:0]                       beat_gap_i,
    input  logic [NumStreams*TDestWidth-1:0] dest_table_i,
    input  logic                             random_ready_i,
    input  logic                             inject_error_i,
    output logic                             m_axis_tvalid_o,
    input  logic                             m_axis_tready_i,
    output logic [TDataWidth-1:0]            m_axis_tdata_o,
    output logic                             m_axis_tlast_o,
    output logic [TIdWidth-1:0]              m_axis_tid_o,
    output logic [TDestWidth-1:0]            m_axis_tdest_o,
    input  logic                             s_axis_tvalid_i,
    output logic                             s_axis_tready_o,
    input  logic [TDataWidth-1:0]            s_axis_tdata_i,
    input  logic                             s_axis_tlast_i,
    input  logic [TIdWidth-1:0]              s_axis_tid_i,
    input  logic [TDestWidth-1:0]            s_axis_tdest_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [15:0]                      tx_packet_count_o,
    output logic [15:0]                      rx_packet_count_o,
    output logic [15:0]                      error_count_o,
    output logic                             error_o
);

    localparam int              SW         = (NumStreams > 1) ? $clog2(NumStreams) : 1;
    localparam logic [SW-1:0]   LastStream = SW'(NumStreams - 1);
    localparam logic [8:0]      MaxLen     = 9'(MaxPacketLength);

    gen_state_e                      state_q, state_d;
    logic [SW-1:0]                   stream_q, stream_d;
    logic [7:0]                      beat_q, beat_d, len_m1_q, len_m1_d;
    logic [3:0]                      gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [15:0]                     num_q, num_d, tx_cnt_q, tx_cnt_d;
    logic [15:0]                     seq_q [NumStreams];
    logic [15:0]                     seq_d [NumStreams];
    logic [NumStreams*TDestWidth-1:0] dest_q, dest_d;
    logic                            done_q, done_d, flip_q, flip_d, pend_q, pend_d;

    logic        hs, last_beat, last_pkt, start_ok;
    logic [8:0]  len_eff;
    logic [31:0] low_word;
    logic        unused_tdest;

    assign unused_tdest = ^s_axis_tdest_i;
    assign start_ok     = start_i && (state_q == GEN_IDLE);
    assign hs           = m_axis_tvalid_o && m_axis_tready_i;
    assign last_beat    = (beat_q == len_m1_q);
    assign last_pkt     = (tx_cnt_q == num_q - 16'd1);

    always_comb begin
        len_eff = {1'b0, packet_length_i};
        if (packet_length_i == 8'd0) len_eff = 9'd1;
        else if ({1'b0, packet_length_i} > MaxLen) len_eff = MaxLen;
    end

    always_comb begin
        state_d   = state_q;
        stream_d  = stream_q;
        beat_d    = beat_q;
        len_m1_d  = len_m1_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        num_d     = num_q;
        tx_cnt_d  = tx_cnt_q;
        seq_d     = seq_q;
        dest_d    = dest_q;
        done_d    = 1'b0;
        case (state_q)
            GEN_IDLE: begin
                if (start_i) begin
                    num_d    = num_packets_i;
                    len_m1_d = 8'(len_eff - 9'd1);
                    gap_d    = beat_gap_i;
                    dest_d   = dest_table_i;
                    stream_d = '0;
                    beat_d   = '0;
                    tx_cnt_d = '0;
                    if (num_packets_i == 16'd0) done_d = 1'b1;
                    else state_d = GEN_SEND;
                end
            end
            GEN_SEND: begin
                if (hs) begin
                    if (last_beat) begin
                        beat_d           = '0;
                        seq_d[stream_q]  = seq_q[stream_q] + 16'd1;
                        tx_cnt_d         = tx_cnt_q + 16'd1;
                        stream_d         = (stream_q == LastStream) ? '0 : stream_q + 1'b1;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                    if (last_beat && last_pkt) begin
                        state_d = GEN_IDLE;
                        done_d  = 1'b1;
                    end else if (gap_q != 4'd0) begin
                        state_d   = GEN_GAP;
                        gap_cnt_d = gap_q;
                    end
                end
            end
            GEN_GAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) state_d = GEN_SEND;
            end
            default: state_d = GEN_IDLE;
        endcase

        // A requested flip is armed only between beats so a stalled beat never changes under tvalid.
        pend_d = pend_q;
        flip_d = flip_q;
        if (state_q == GEN_SEND && !hs) begin
            pend_d = pend_q | inject_error_i;
        end else if (hs) begin
            flip_d = pend_q | inject_error_i;
            pend_d = 1'b0;
        end else begin
            flip_d = flip_q | inject_error_i;
        end
    end

    always_ff @(posedge clk_axis_i) begin
        if (rst_axis_i) begin
            state_q   <= GEN_IDLE;
            stream_q  <= '0;
            beat_q    <= '0;
            len_m1_q  <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            num_q     <= '0;
            tx_cnt_q  <= '0;
            dest_q    <= '0;
            done_q    <= 1'b0;
            flip_q    <= 1'b0;
            pend_q    <= 1'b0;
            for (int s = 0; s < NumStreams; s++) seq_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            stream_q  <= stream_d;
            beat_q    <= beat_d;
            len_m1_q  <= len_m1_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            num_q     <= num_d;
            tx_cnt_q  <= tx_cnt_d;
            dest_q    <= dest_d;
            done_q    <= done_d;
            flip_q    <= flip_d;
            pend_q    <= pend_d;
            seq_q     <= seq_d;
        end
    end

    always_comb begin
        low_word = make_beat(seq_q[stream_q], beat_q, len_m1_q);
        for (int i = 0; i < TDataWidth; i++) begin
            m_axis_tdata_o[i] = (i < 32) ? low_word[i % 32] : (low_word[i % 32] ^ PatternMask[i % 32]);
        end
        m_axis_tdata_o[0] = low_word[0] ^ flip_q;
    end

    assign m_axis_tvalid_o   = (state_q == GEN_SEND);
    assign m_axis_tlast_o    = last_beat;
    assign m_axis_tid_o      = TIdWidth'(SrcId);
    assign m_axis_tdest_o    = dest_q[stream_q*TDestWidth +: TDestWidth];
    assign busy_o            = (state_q != GEN_IDLE);
    assign done_o            = done_q;
    assign tx_packet_count_o = tx_cnt_q;

    axis_traffic_checker #(
        .TDataWidth (TDataWidth),
        .TIdWidth   (TIdWidth)
    ) u_checker (
        .clk_i             (clk_axis_i),
        .rst_i             (rst_axis_i),
        .clear_i           (start_ok),
        .random_ready_i    (random_ready_i),
        .s_axis_tvalid_i   (s_axis_tvalid_i),
        .s_axis_tready_o   (s_axis_tready_o),
        .s_axis_tdata_i    (s_axis_tdata_i),
        .s_axis_tlast_i    (s_axis_tlast_i),
        .s_axis_tid_i      (s_axis_tid_i),
        .rx_packet_count_o (rx_packet_count_o),
        .error_count_o     (error_count_o),
        .error_o           (error_o)
    );

endmodule

// File: tb/tb_axis_traffic_tile.sv
// tb/tb_axis_traffic_tile.sv - directed self-checking bench for axis_traffic_tile
module tb_axis_traffic_tile;

    localparam int DW  = 64;
    localparam int IW  = 5;
    localparam int DSW = 5;
    localparam int NS  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1, start = 1'b0, random_ready = 1'b0, inject = 1'b0;
    logic [15:0]     num = '0;
    logic [7:0]      plen = '0;
    logic [3:0]      gap = '0;
    logic [NS*DSW-1:0] dest_table = {5'd2, 5'd1};

    logic            m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [IW-1:0]   m_tid;
    logic [DSW-1:0]  m_tdest;
    logic            s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]   s_tdata;
    logic [IW-1:0]   s_tid;
    logic [DSW-1:0]  s_tdest;
    logic            busy, done, err_flag;
    logic [15:0]     tx_cnt, rx_cnt, err_cnt;

    // Loopback with tid taken from tdest gives each generator stream its own checker context.
    logic            drv_s = 1'b0, stall = 1'b0, d_tvalid = 1'b0, d_tlast = 1'b0;
    logic [DW-1:0]   d_tdata = '0;
    logic [IW-1:0]   d_tid = '0;

    assign s_tvalid = drv_s ? d_tvalid : (m_tvalid & ~stall);
    assign s_tdata  = drv_s ? d_tdata  : m_tdata;
    assign s_tlast  = drv_s ? d_tlast  : m_tlast;
    assign s_tid    = drv_s ? d_tid    : m_tdest;
    assign s_tdest  = m_tdest;
    assign m_tready = s_tready & ~stall;

    axis_traffic_tile #(
        .TDataWidth(DW), .TIdWidth(IW), .TDestWidth(DSW),
        .NumStreams(NS), .MaxPacketLength(16), .SrcId(0)
    ) dut (
        .clk_axis_i(clk), .rst_axis_i(rst), .start_i(start),
        .num_packets_i(num), .packet_length_i(plen), .beat_gap_i(gap),
        .dest_table_i(dest_table), .random_ready_i(random_ready), .inject_error_i(inject),
        .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready), .m_axis_tdata_o(m_tdata),
        .m_axis_tlast_o(m_tlast), .m_axis_tid_o(m_tid), .m_axis_tdest_o(m_tdest),
        .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready), .s_axis_tdata_i(s_tdata),
        .s_axis_tlast_i(s_tlast), .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_tdest),
        .busy_o(busy), .done_o(done), .tx_packet_count_o(tx_cnt),
        .rx_packet_count_o(rx_cnt), .error_count_o(err_cnt), .error_o(err_flag)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int          beats, pkts, dones, idle, min_gap;
    logic [4:0]  pkt_dest [16];
    logic [15:0] pkt_seq  [16];
    logic [63:0] first_data, last_data, held_data;
    logic        held, held_last;
    logic [4:0]  held_dest;

    initial held = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_tvalid", m_tvalid, 1'b1);
                check("stall_tdata", m_tdata, held_data);
                check("stall_tlast", m_tlast, held_last);
                check("stall_tdest", m_tdest, held_dest);
            end
            if (m_tvalid && m_tready) begin
                if (beats == 0) first_data = m_tdata;
                else if (idle < min_gap) min_gap = idle;
                last_data = m_tdata;
                idle = 0;
                beats++;
                if (m_tlast) begin
                    if (pkts < 16) begin
                        pkt_dest[pkts] = m_tdest;
                        pkt_seq[pkts]  = m_tdata[31:16];
                    end
                    pkts++;
                end
            end else begin
                idle++;
            end
            if (done) dones++;
            held      = m_tvalid && !m_tready;
            held_data = m_tdata;
            held_last = m_tlast;
            held_dest = m_tdest;
        end
    end

    task automatic run(input logic [15:0] n, input logic [7:0] l, input logic [3:0] g);
        @(negedge clk);
        beats = 0; pkts = 0; dones = 0; idle = 0; min_gap = 99;
        num = n; plen = l; gap = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (dones == 0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", dones, 1);
    endtask

    task automatic send_s(input logic [15:0] seq);
        logic [31:0] low;
        low = {seq, 16'h0000};
        @(negedge clk);
        d_tvalid = 1'b1; d_tlast = 1'b1; d_tid = 5'd3;
        d_tdata  = {low ^ 32'hA5A5A5A5, low};
        @(negedge clk);
        d_tvalid = 1'b0;
    endtask

    initial begin
        beats = 0; pkts = 0; dones = 0; idle = 0; min_gap = 99;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx", tx_cnt, 16'd0);
        check("rst_rx", rx_cnt, 16'd0);
        check("rst_errcnt", err_cnt, 16'd0);
        check("rst_error", err_flag, 1'b0);
        check("rst_s_tready", s_tready, 1'b1);

        run(16'd3, 8'd4, 4'd0);
        wait_done(200);
        check("t1_beats", beats, 12);
        check("t1_dest0", pkt_dest[0], 5'd1);
        check("t1_dest1", pkt_dest[1], 5'd2);
        check("t1_dest2", pkt_dest[2], 5'd1);
        check("t1_seq0", pkt_seq[0], 16'd0);
        check("t1_seq1", pkt_seq[1], 16'd0);
        check("t1_seq2", pkt_seq[2], 16'd1);
        check("t1_first_beat", first_data, 64'hA5A5A5A6_00000003);
        check("t1_min_gap", min_gap, 0);
        check("t1_tx", tx_cnt, 16'd3);
        check("t1_rx", rx_cnt, 16'd3);
        check("t1_errcnt", err_cnt, 16'd0);
        check("t1_busy", busy, 1'b0);

        run(16'd2, 8'd2, 4'd3);
        wait_done(200);
        check("gap_beats", beats, 4);
        check("gap_min", min_gap, 3);
        check("gap_errcnt", err_cnt, 16'd0);

        random_ready = 1'b1;
        run(16'd100, 8'd16, 4'd0);
        wait_done(20000);
        random_ready = 1'b0;
        check("lb_beats", beats, 1600);
        check("lb_tx", tx_cnt, 16'd100);
        check("lb_rx", rx_cnt, 16'd100);
        check("lb_errcnt", err_cnt, 16'd0);

        run(16'd2, 8'd4, 4'd0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        wait_done(200);
        check("inj_errcnt", err_cnt, 16'd1);
        check("inj_error", err_flag, 1'b1);
        check("inj_rx", rx_cnt, 16'd2);
        run(16'd1, 8'd4, 4'd0);
        wait_done(200);
        check("inj_clean_errcnt", err_cnt, 16'd0);
        check("inj_clean_error", err_flag, 1'b0);

        @(negedge clk);
        num = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("num0_done", done, 1'b1);
        check("num0_tvalid", m_tvalid, 1'b0);
        check("num0_busy", busy, 1'b0);
        @(negedge clk);
        check("num0_done_low", done, 1'b0);

        drv_s = 1'b1;
        send_s(16'd0);
        check("rs_seq0_err", err_cnt, 16'd0);
        send_s(16'd2);
        check("rs_seq2_err", err_cnt, 16'd1);
        check("rs_seq2_flag", err_flag, 1'b1);
        send_s(16'd3);
        check("rs_seq3_err", err_cnt, 16'd1);
        check("rs_rx", rx_cnt, 16'd3);
        drv_s = 1'b0;

        run(16'd1, 8'd0, 4'd0);
        wait_done(100);
        check("len0_beats", beats, 1);
        check("len0_field", first_data[7:0], 8'd0);
        run(16'd1, 8'(300), 4'd0);
        wait_done(200);
        check("lenmax_beats", beats, 16);
        check("lenmax_last_idx", last_data[15:8], 8'd15);
        check("lenmax_errcnt", err_cnt, 16'd0);

        run(16'd2, 8'd8, 4'd0);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        check("mid_tvalid", m_tvalid, 1'b1);
        check("mid_beat_idx", m_tdata[15:8], 8'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_tvalid", m_tvalid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_tx", tx_cnt, 16'd0);
        check("mrst_rx", rx_cnt, 16'd0);
        check("mrst_errcnt", err_cnt, 16'd0);
        stall = 1'b0;
        run(16'd2, 8'd8, 4'd0);
        wait_done(200);
        check("rerun_first", first_data, 64'hA5A5A5A2_00000007);
        check("rerun_beats", beats, 16);
        check("rerun_rx", rx_cnt, 16'd2);
        check("rerun_errcnt", err_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
